// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM state encoding and default
// transfer geometry.
package spi_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_CLK_DIV = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEAD  = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_TRAIL = 3'd4,
    ST_GAP   = 3'd5
  } spi_state_e;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period tick generator: counts 0..CLK_DIV-1 and flags the last cycle
// of each SCLK half-period; held at zero while cleared.
module spi_clk_gen import spi_pkg::*; #(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_s;
  logic          tick_r;

  // Next count: wrap at the end of a half-period, hold zero when cleared.
  always_comb begin
    cnt_s = cnt_r;
    if (clear_i) begin
      cnt_s = '0;
    end else if (cnt_r == LAST_CNT) begin
      cnt_s = '0;
    end else begin
      cnt_s = cnt_r + CW'(1'b1);
    end
  end

  // Counter and registered tick, so the tick is high during the last cycle.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_s;
      tick_r <= (cnt_s == LAST_CNT);
    end
  end

  assign tick_o = tick_r;

endmodule

// File: rtl/spi_master.sv
// SPI master, mode 0 (CPOL=0, CPHA=0), all outputs registered.
// Define SPI_MASTER_LSB_FIRST_EN for LSB-first tx/rx; default is MSB first.
module spi_master import spi_pkg::*; #(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] data_tx_i,
  input  logic             miso_i,
  output logic             sclk_o,
  output logic             ss_n_o,
  output logic             mosi_o,
  output logic [WIDTH-1:0] data_rx_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH);

  spi_state_e       state_r, state_s;
  logic             sclk_r, sclk_s;
  logic             ss_n_r, ss_n_s;
  logic             mosi_r, mosi_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic [WIDTH-1:0] tx_shift_r, tx_shift_s;
  logic [WIDTH-1:0] rx_shift_r, rx_shift_s;
  logic [WIDTH-1:0] rx_data_r, rx_data_s;
  logic [CNT_W-1:0] bit_cnt_r, bit_cnt_s;
  logic             tick_s;
  logic             first_bit_s;
  logic             next_bit_s;
  logic [WIDTH-1:0] tx_next_s;
  logic [WIDTH-1:0] rx_next_s;

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (state_r == ST_IDLE),
    .tick_o    (tick_s)
  );

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign first_bit_s = data_tx_i[0];
  assign tx_next_s   = tx_shift_r >> 1'b1;
  assign next_bit_s  = tx_next_s[0];
  assign rx_next_s   = {miso_i, rx_shift_r[WIDTH-1:1]};
`else
  assign first_bit_s = data_tx_i[WIDTH-1];
  assign tx_next_s   = tx_shift_r << 1'b1;
  assign next_bit_s  = tx_next_s[WIDTH-1];
  assign rx_next_s   = {rx_shift_r[WIDTH-2:0], miso_i};
`endif

  // Next-state and next-output logic; every output is computed here and registered below.
  always_comb begin
    state_s    = state_r;
    sclk_s     = sclk_r;
    ss_n_s     = ss_n_r;
    mosi_s     = mosi_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    tx_shift_s = tx_shift_r;
    rx_shift_s = rx_shift_r;
    rx_data_s  = rx_data_r;
    bit_cnt_s  = bit_cnt_r;
    case (state_r)
      ST_IDLE: begin
        sclk_s    = 1'b0;
        ss_n_s    = 1'b1;
        mosi_s    = 1'b0;
        busy_s    = 1'b0;
        bit_cnt_s = '0;
        if (start_i) begin
          state_s    = ST_LEAD;
          ss_n_s     = 1'b0;
          busy_s     = 1'b1;
          mosi_s     = first_bit_s;
          tx_shift_s = data_tx_i;
          rx_shift_s = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LEAD: begin
        if (tick_s) begin
          state_s    = ST_HIGH;
          sclk_s     = 1'b1;
          rx_shift_s = rx_next_s;
          bit_cnt_s  = bit_cnt_r + CNT_W'(1'b1);
        end else begin
          state_s = ST_LEAD;
        end
      end
      ST_HIGH: begin
        if (tick_s) begin
          state_s    = ST_LOW;
          sclk_s     = 1'b0;
          tx_shift_s = tx_next_s;
          mosi_s     = next_bit_s;
        end else begin
          state_s = ST_HIGH;
        end
      end
      ST_LOW: begin
        if (tick_s) begin
          if (bit_cnt_r == LAST_BIT) begin
            state_s = ST_TRAIL;
          end else begin
            state_s    = ST_HIGH;
            sclk_s     = 1'b1;
            rx_shift_s = rx_next_s;
            bit_cnt_s  = bit_cnt_r + CNT_W'(1'b1);
          end
        end else begin
          state_s = ST_LOW;
        end
      end
      ST_TRAIL: begin
        if (tick_s) begin
          state_s   = ST_GAP;
          ss_n_s    = 1'b1;
          mosi_s    = 1'b0;
          done_s    = 1'b1;
          rx_data_s = rx_shift_r;
        end else begin
          state_s = ST_TRAIL;
        end
      end
      ST_GAP: begin
        if (tick_s) begin
          state_s = ST_IDLE;
          busy_s  = 1'b0;
        end else begin
          state_s = ST_GAP;
        end
      end
      default: begin
        state_s = ST_IDLE;
        sclk_s  = 1'b0;
        ss_n_s  = 1'b1;
        mosi_s  = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops the link to idle immediately.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r    <= ST_IDLE;
      sclk_r     <= 1'b0;
      ss_n_r     <= 1'b1;
      mosi_r     <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      tx_shift_r <= '0;
      rx_shift_r <= '0;
      rx_data_r  <= '0;
      bit_cnt_r  <= '0;
    end else begin
      state_r    <= state_s;
      sclk_r     <= sclk_s;
      ss_n_r     <= ss_n_s;
      mosi_r     <= mosi_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      tx_shift_r <= tx_shift_s;
      rx_shift_r <= rx_shift_s;
      rx_data_r  <= rx_data_s;
      bit_cnt_r  <= bit_cnt_s;
    end
  end

  assign sclk_o    = sclk_r;
  assign ss_n_o    = ss_n_r;
  assign mosi_o    = mosi_r;
  assign busy_o    = busy_r;
  assign done_o    = done_r;
  assign data_rx_o = rx_data_r;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: instance A (CLK_DIV=2) with a mode-0 slave
// model, instance B (CLK_DIV=4) for phase-length and done timing.
module tb_spi_master;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         start_a, start_b;
  logic [W-1:0] tx_a, tx_b;
  logic         miso_a;
  logic         sclk_a, ss_n_a, mosi_a, busy_a, done_a;
  logic         sclk_b, ss_n_b, mosi_b, busy_b, done_b;
  logic [W-1:0] data_rx_a, data_rx_b;

  spi_master #(.WIDTH(W), .CLK_DIV(2)) dut_a (
    .clk_i(clk), .reset_n_i(rst_n), .start_i(start_a), .data_tx_i(tx_a),
    .miso_i(miso_a), .sclk_o(sclk_a), .ss_n_o(ss_n_a), .mosi_o(mosi_a),
    .data_rx_o(data_rx_a), .busy_o(busy_a), .done_o(done_a)
  );

  spi_master #(.WIDTH(W), .CLK_DIV(4)) dut_b (
    .clk_i(clk), .reset_n_i(rst_n), .start_i(start_b), .data_tx_i(tx_b),
    .miso_i(1'b1), .sclk_o(sclk_b), .ss_n_o(ss_n_b), .mosi_o(mosi_b),
    .data_rx_o(data_rx_b), .busy_o(busy_b), .done_o(done_b)
  );

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] bitrev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[W-1-i];
    return r;
  endfunction

  function automatic logic [W-1:0] exp_seq(input logic [W-1:0] v);
`ifdef SPI_MASTER_LSB_FIRST_EN
    return bitrev(v);
`else
    return v;
`endif
  endfunction

  // Mode-0 slave: first bit valid at ss_n fall, next bit after each sclk fall.
  logic [W-1:0] slv_word = '0;
  int           slv_k = 0;
  always @(negedge ss_n_a) slv_k <= 0;
  always @(negedge sclk_a) slv_k <= slv_k + 1;
  always_comb begin
    miso_a = 1'b0;
    if (slv_k < W) begin
`ifdef SPI_MASTER_LSB_FIRST_EN
      miso_a = slv_word[slv_k[2:0]];
`else
      miso_a = slv_word[3'(W - 1 - slv_k)];
`endif
    end
  end

  // Monitor for A: sclk rises, mosi sampled at each rise, ss_n low time, done pulses.
  logic         sclk_a_q = 1'b0;
  int           rise_a = 0, ss_low_a = 0, done_a_cnt = 0, mosi_bad_a = 0;
  logic [W-1:0] mosi_seq_a = '0;
  always @(negedge clk) begin
    sclk_a_q <= sclk_a;
    if (sclk_a && !sclk_a_q) begin
      rise_a     <= rise_a + 1;
      mosi_seq_a <= {mosi_seq_a[W-2:0], mosi_a};
    end
    if (!ss_n_a) ss_low_a <= ss_low_a + 1;
    if (done_a) done_a_cnt <= done_a_cnt + 1;
    if (ss_n_a && mosi_a) mosi_bad_a <= mosi_bad_a + 1;
  end

  // Monitor for B: length of every sclk level run while ss_n is low.
  logic lvl_b = 1'b0;
  int   run_b = 0, hi_runs = 0, lo_runs = 0, hi_bad = 0, lo_bad = 0, mosi_bad_b = 0;
  always @(negedge clk) begin
    if (ss_n_b && mosi_b) mosi_bad_b <= mosi_bad_b + 1;
    if (ss_n_b) begin
      run_b <= 0;
      lvl_b <= sclk_b;
    end else if (sclk_b == lvl_b) begin
      run_b <= run_b + 1;
    end else begin
      if (lvl_b) begin
        hi_runs <= hi_runs + 1;
        if (run_b != 4) hi_bad <= hi_bad + 1;
      end else begin
        lo_runs <= lo_runs + 1;
        if (run_b != 4) lo_bad <= lo_bad + 1;
      end
      lvl_b <= sclk_b;
      run_b <= 1;
    end
  end

  task automatic wait_idle_a();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!busy_a) begin ok = 1'b1; break; end
    end
    check("idle_wait_a", ok, 1'b1);
  endtask

  task automatic xfer_a(input logic [W-1:0] tx, input logic [W-1:0] tx_late, input logic [W-1:0] slv);
    int r0, s0, d0;
    bit seen;
    logic [W-1:0] first;
    wait_idle_a();
    seen = 1'b0;
    first = exp_seq(tx);
    @(posedge clk);
    r0 = rise_a; s0 = ss_low_a; d0 = done_a_cnt;
    slv_word = slv;
    @(negedge clk);
    tx_a = tx; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; tx_a = tx_late;
    check("accept_busy", busy_a, 1'b1);
    check("accept_ss_n", ss_n_a, 1'b0);
    check("first_mosi", mosi_a, first[W-1]);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done_a) begin seen = 1'b1; break; end
    end
    check("done_seen", seen, 1'b1);
    check("rx_word", data_rx_a, slv);
    check("busy_in_gap", busy_a, 1'b1);
    @(posedge clk);
    check("sclk_rises", rise_a - r0, 8);
    check("ss_low_cycles", ss_low_a - s0, 36);
    check("done_pulses", done_a_cnt - d0, 1);
    check("mosi_bits", mosi_seq_a, exp_seq(tx));
  endtask

  int r0, d0, n_done, gap_hi, gap_idle, t_done;
  bit in_gap, seen;

  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; tx_a = '0; tx_b = '0;
    repeat (3) @(negedge clk);
    check("rst_sclk", sclk_a, 1'b0);
    check("rst_ss_n", ss_n_a, 1'b1);
    check("rst_mosi", mosi_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_rx", data_rx_a, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", busy_a, 1'b0);
    check("idle_ss_n_b", ss_n_b, 1'b1);

    xfer_a(8'hA5, 8'hA5, 8'h3C);
    xfer_a(8'h5A, 8'h5A, 8'hC3);
    xfer_a(8'h01, 8'h01, 8'h80);
    xfer_a(8'h00, 8'hFF, 8'hFF);

    // start held high across two transfers
    wait_idle_a();
    @(posedge clk);
    r0 = rise_a; d0 = done_a_cnt;
    slv_word = 8'h69;
    @(negedge clk);
    tx_a = 8'h96; start_a = 1'b1;
    n_done = 0; gap_hi = 0; gap_idle = 0; in_gap = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done_a) begin n_done++; in_gap = (n_done == 1); end
      if (in_gap && ss_n_a) gap_hi++;
      if (in_gap && !busy_a) gap_idle++;
      if (in_gap && !ss_n_a) in_gap = 1'b0;
      if (n_done == 2) break;
    end
    start_a = 1'b0;
    check("b2b_done_seen", n_done, 2);
    check("b2b_ss_high", gap_hi, 3);
    check("b2b_idle_cycles", gap_idle, 1);
    check("b2b_rx", data_rx_a, 8'h69);
    @(posedge clk);
    check("b2b_rises", rise_a - r0, 16);
    check("b2b_mosi", mosi_seq_a, exp_seq(8'h96));
    repeat (12) @(negedge clk);
    check("b2b_no_third", busy_a, 1'b0);
    @(posedge clk);
    check("b2b_done_total", done_a_cnt - d0, 2);

    // reset after the 3rd sclk rise
    @(posedge clk);
    r0 = rise_a; d0 = done_a_cnt;
    slv_word = 8'hFF;
    @(negedge clk);
    tx_a = 8'hF0; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (rise_a - r0 >= 3) begin seen = 1'b1; break; end
    end
    check("rise3_seen", seen, 1'b1);
    check("pre_rst_sclk", sclk_a, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_sclk", sclk_a, 1'b0);
    check("arst_ss_n", ss_n_a, 1'b1);
    check("arst_busy", busy_a, 1'b0);
    check("arst_mosi", mosi_a, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("arst_rx_cleared", data_rx_a, 8'h00);
    @(posedge clk);
    check("arst_no_done", done_a_cnt - d0, 0);
    xfer_a(8'h81, 8'h81, 8'h42);

    // CLK_DIV=4 phase lengths and done timing
    @(negedge clk);
    tx_b = 8'h3C; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    check("b_ss_fall", ss_n_b, 1'b0);
    t_done = -1;
    for (int i = 1; i < 400; i++) begin
      @(negedge clk);
      if (done_b) begin t_done = i; break; end
    end
    check("b_done_delay", t_done, 72);
    check("b_rx", data_rx_b, 8'hFF);
    @(posedge clk);
    check("b_high_phases", hi_runs, 8);
    check("b_low_phases", lo_runs, 8);
    check("b_high_len_bad", hi_bad, 0);
    check("b_low_len_bad", lo_bad, 0);
    repeat (8) @(negedge clk);
    check("b_idle", busy_b, 1'b0);
    check("mosi_idle_a", mosi_bad_a, 0);
    check("mosi_idle_b", mosi_bad_b, 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning bits per transfer (legal 2..32).
REQ-002 SHALL have parameter CLK_DIV, default 4, meaning clk_i cycles per SCLK half-period (legal >= 2).
REQ-003 SHALL have ports in this order: clk_i  in  1  system clock (the only clock); reset_n_i  in  1  reset (one clock; reset is asynchronous and active-low).
REQ-004 SHALL have port start_i  in  1  transfer request, sampled only in IDLE.
REQ-005 SHALL have port data_tx_i  in  WIDTH  word to send, latched on start acceptance.
REQ-006 SHALL have port miso_i  in  1  serial data from the slave.
REQ-007 SHALL have port sclk_o  out  1  SPI clock, CPOL=0 (idle low).
REQ-008 SHALL have port ss_n_o  out  1  slave select, active low.
REQ-009 SHALL have port mosi_o  out  1  serial data to the slave.
REQ-010 SHALL have port data_rx_o  out  WIDTH  last received word, held until the next done_o.
REQ-011 SHALL have port busy_o  out  1  high in every state except IDLE.
REQ-012 SHALL have port done_o  out  1  one-cycle pulse at transfer end.

Function
REQ-013 SHALL implement states IDLE, LEAD, HIGH, LOW, TRAIL, GAP; all outputs registered.
REQ-014 IDLE: start_i=1 -> latch data_tx_i into shift reg, drive mosi_o with first bit, ss_n_o low next cycle, go LEAD; start_i=0 -> stay.
REQ-015 LEAD: hold sclk_o low CLK_DIV cycles, then go HIGH.
REQ-016 HIGH: sclk_o high CLK_DIV cycles; capture miso_i into rx shift reg on the cycle sclk_o rises; then go LOW.
REQ-017 LOW: sclk_o low CLK_DIV cycles; on entry (falling SCLK) drive next tx bit on mosi_o; after bit WIDTH-1 go TRAIL, else HIGH.
REQ-018 Bit counter SHALL be $clog2(WIDTH)+1 bits, cleared in IDLE, incremented per SCLK rising edge; exactly WIDTH rising edges per transfer.
REQ-019 TRAIL: sclk_o low, ss_n_o low CLK_DIV cycles; on exit ss_n_o high, done_o=1 for one cycle, data_rx_o updated same cycle; go GAP.
REQ-020 GAP: ss_n_o high CLK_DIV cycles, busy_o high, then IDLE.
REQ-021 ss_n_o SHALL be low for exactly (2*WIDTH+2)*CLK_DIV cycles per transfer.
REQ-022 Default bit order SHALL be MSB first for both mosi_o and miso_i.
REQ-023 start_i while busy_o=1 SHALL be ignored, not queued; data_tx_i changes after acceptance SHALL not affect the transfer.
REQ-024 start_i asserted in the first IDLE cycle after GAP SHALL be accepted (no extra idle cycle).
REQ-025 mosi_o SHALL be 0 whenever ss_n_o is high.

Reset
REQ-026 reset_n_i low SHALL immediately force: state IDLE, sclk_o=0, ss_n_o=1, mosi_o=0, busy_o=0, done_o=0, data_rx_o=0, counters and shift regs 0.
REQ-027 Reset mid-transfer SHALL abort without a done_o pulse; first transfer after release behaves as from power-up.

Configuration
REQ-028 With macro SPI_MASTER_LSB_FIRST_EN defined, tx and rx SHALL be LSB first; undefined, MSB first per REQ-022; timing identical either way.

Structure
REQ-029 Package spi_pkg SHALL hold the state encoding typedef and default WIDTH/CLK_DIV constants.
REQ-030 Sub-module spi_clk_gen SHALL provide the half-period tick counter (counts 0..CLK_DIV-1, cleared in IDLE).

Verification
REQ-031 WIDTH=8, CLK_DIV=2, start with 0xA5, slave model returns 0x3C -> mosi bits 1,0,1,0,0,1,0,1; data_rx_o=0x3C; ss_n_o low 36 cycles; one done_o pulse.
REQ-032 start_i held high throughout two transfers -> second starts exactly 1 cycle after GAP ends; 8 SCLK rises each; no start taken while busy.
REQ-033 data_tx_i changed to 0xFF in LEAD of a 0x00 transfer -> mosi_o stays 0 all 8 bits.
REQ-034 reset_n_i pulsed low after 3rd SCLK rise -> same cycle sclk_o=0, ss_n_o=1, busy_o=0; no done_o; next 0x81 transfer correct.
REQ-035 With SPI_MASTER_LSB_FIRST_EN, send 0x01, slave returns 0x80 sent LSB first -> first mosi bit 1; data_rx_o=0x80.
REQ-036 CLK_DIV=4 -> every sclk_o high and low phase exactly 4 cycles; done_o exactly (2*8+2)*4 cycles after ss_n_o falls.
